// File: rtl/hps_reset_pkg.sv
// ---------------------------------------------------------------------------
// hps_reset_pkg
// Shared types for the HPS reset-request generator:
//   state_t    - request sequencer states
//   req_kind_t - encoding of the request kind, also exported on last_req
//   pick_event - same-cycle arbitration between the three button events
// ---------------------------------------------------------------------------
package hps_reset_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ASSERT       = 3'd1,
        WAIT_ACK     = 3'd2,
        WAIT_RELEASE = 3'd3,
        HOLDOFF      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        WARM  = 2'b01,
        COLD  = 2'b10,
        DEBUG = 2'b11
    } req_kind_t;

    // Cold beats warm beats debug; anything that loses is simply dropped.
    function automatic req_kind_t pick_event(input logic cold_ev,
                                             input logic warm_ev,
                                             input logic debug_ev);
        if (cold_ev) begin
            return COLD;
        end else if (warm_ev) begin
            return WARM;
        end else if (debug_ev) begin
            return DEBUG;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/hps_reset_req_gen_debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
// Two-flop synchroniser followed by a debounce counter for one active-low
// push-button. The debounced level only changes after DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with it, so shorter glitches
// never reach the output.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   din_n   - raw button level (active-low, asynchronous to clk)
//   level_n - debounced button level (1 = released), registered
// ---------------------------------------------------------------------------
module debounce_sync
    import hps_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_n,
    output logic level_n
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            // Counter holds the number of disagreeing samples seen so far;
            // the one that brings it to DEBOUNCE_CYCLES commits the change.
            if ((cnt_q + CNT_ONE) >= DEB_MAX) begin
                level_d = sync_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q  <= din_n;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_n = level_q;

endmodule

// File: rtl/hps_reset_req_gen.sv
// ---------------------------------------------------------------------------
// hps_reset_req_gen
// Fabric-side driver for the HPS f2h cold/warm/debug reset requests.
// button[0]: short press (released before LONG_CYCLES) -> warm request,
//            long hold (reaching LONG_CYCLES)         -> cold request.
// button[1]: press -> debug request.
// Each accepted request is pulsed low for PULSE_CYCLES; warm/cold then wait
// for the HPS to enter and leave reset (h2f_reset_n), debug skips that.
// A HOLDOFF lockout follows every request.
// Ports:
//   clk_clk               - clock
//   reset_reset_n         - asynchronous active-low reset
//   button_n[1:0]         - raw active-low push-buttons
//   h2f_reset_n           - HPS reset output (asynchronous, active-low)
//   f2h_*_reset_req_n     - registered active-low request outputs
//   busy                  - sequencer not idle
//   last_req              - kind of the last issued request (req_kind_t)
//   ack_timeout           - sticky: HPS did not acknowledge the last request
// ---------------------------------------------------------------------------
module hps_reset_req_gen
    import hps_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 150000000,
    parameter int PULSE_CYCLES    = 64,
    parameter int ACK_TIMEOUT     = 1000000,
    parameter int HOLDOFF_CYCLES  = 50000000,
    parameter int CNT_W           = 32
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [1:0] button_n,
    input  logic       h2f_reset_n,
    output logic       f2h_cold_reset_req_n,
    output logic       f2h_warm_reset_req_n,
    output logic       f2h_debug_reset_req_n,
    output logic       busy,
    output logic [1:0] last_req,
    output logic       ack_timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] btn_level_n;   // debounced, 1 = released
    logic [1:0] btn_prev_q;    // previous debounced level, for edge detect
    logic [1:0] btn_prev_d;
    logic       h2f_meta_q;
    logic       h2f_sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            debounce_sync #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk     (clk_clk),
                .rst_n   (reset_reset_n),
                .din_n   (button_n[gi]),
                .level_n (btn_level_n[gi])
            );
        end
    endgenerate

    assign btn_prev_d = btn_level_n;

    // ------------------------------------------------------------------
    // Hold timer and event generation
    // ------------------------------------------------------------------
    logic             b0_pressed;
    logic             b0_release_edge;
    logic             b1_press_edge;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             cold_ev;
    logic             warm_ev;
    logic             debug_ev;
    logic             any_ev;
    req_kind_t        ev_kind;
    logic             accept;

    assign b0_pressed      = !btn_level_n[0];
    assign b0_release_edge = !btn_prev_q[0] &&  btn_level_n[0];
    assign b1_press_edge   =  btn_prev_q[1] && !btn_level_n[1];

    always_comb begin
        hold_d = '0;
        if (b0_pressed) begin
            hold_d = (hold_q >= LONG_MAX) ? hold_q : (hold_q + CNT_ONE);
        end
    end

    // Cold fires on the single cycle the hold timer steps onto LONG_CYCLES;
    // the timer then sits saturated so it cannot fire again this press.
    // On the release edge hold_q still carries the pressed-period count,
    // which decides whether the release was a short (warm) press.
    assign cold_ev  = b0_pressed && (hold_q == LONG_LAST);
    assign warm_ev  = b0_release_edge && (hold_q < LONG_MAX);
    assign debug_ev = b1_press_edge;
    assign any_ev   = cold_ev || warm_ev || debug_ev;
    assign ev_kind  = pick_event(cold_ev, warm_ev, debug_ev);

    // ------------------------------------------------------------------
    // Request sequencer
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    req_kind_t        kind_q;
    req_kind_t        kind_d;
    req_kind_t        last_req_q;
    req_kind_t        last_req_d;
    logic             ack_timeout_q;
    logic             ack_timeout_d;
    logic             cold_n_q;
    logic             cold_n_d;
    logic             warm_n_q;
    logic             warm_n_d;
    logic             debug_n_q;
    logic             debug_n_d;
    logic             busy_q;
    logic             busy_d;

    // Events are only looked at while idle and while the HPS is out of reset.
    assign accept = (state_q == IDLE) && h2f_sync_q && any_ev;

    // State register (plus the conditioning/datapath flops)
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            kind_q        <= NONE;
            last_req_q    <= NONE;
            ack_timeout_q <= 1'b0;
            cold_n_q      <= 1'b1;
            warm_n_q      <= 1'b1;
            debug_n_q     <= 1'b1;
            busy_q        <= 1'b0;
            hold_q        <= '0;
            btn_prev_q    <= 2'b11;
            // Start as "HPS in reset" so nothing is accepted until the real
            // level has made it through the synchroniser.
            h2f_meta_q    <= 1'b0;
            h2f_sync_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            kind_q        <= kind_d;
            last_req_q    <= last_req_d;
            ack_timeout_q <= ack_timeout_d;
            cold_n_q      <= cold_n_d;
            warm_n_q      <= warm_n_d;
            debug_n_q     <= debug_n_d;
            busy_q        <= busy_d;
            hold_q        <= hold_d;
            btn_prev_q    <= btn_prev_d;
            h2f_meta_q    <= h2f_reset_n;
            h2f_sync_q    <= h2f_meta_q;
        end
    end

    // Next-state logic; the shared counter is cleared on every transition.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        kind_d        = kind_q;
        last_req_d    = last_req_q;
        ack_timeout_d = ack_timeout_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    kind_d        = ev_kind;
                    last_req_d    = ev_kind;
                    ack_timeout_d = 1'b0;
                    state_d       = ASSERT;
                end
            end
            ASSERT: begin
                if (cnt_q >= PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = (kind_q == DEBUG) ? HOLDOFF : WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_ACK: begin
                if (!h2f_sync_q) begin
                    cnt_d   = '0;
                    state_d = WAIT_RELEASE;
                end else if (cnt_q >= ACK_LAST) begin
                    cnt_d         = '0;
                    ack_timeout_d = 1'b1;
                    state_d       = HOLDOFF;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_RELEASE: begin
                // No timeout here: the HPS decides how long reset lasts.
                cnt_d = '0;
                if (h2f_sync_q) begin
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt_q >= HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output logic, decoded from the next state so the registered outputs
    // line up exactly with the cycles spent in ASSERT.
    always_comb begin
        cold_n_d  = !((state_d == ASSERT) && (kind_d == COLD));
        warm_n_d  = !((state_d == ASSERT) && (kind_d == WARM));
        debug_n_d = !((state_d == ASSERT) && (kind_d == DEBUG));
        busy_d    = (state_d != IDLE);
    end

    assign f2h_cold_reset_req_n  = cold_n_q;
    assign f2h_warm_reset_req_n  = warm_n_q;
    assign f2h_debug_reset_req_n = debug_n_q;
    assign busy                  = busy_q;
    assign last_req              = last_req_q;
    assign ack_timeout           = ack_timeout_q;

endmodule

// File: tb/tb_hps_reset_req_gen.sv
// ---------------------------------------------------------------------------
// tb_hps_reset_req_gen
// Directed bench for hps_reset_req_gen with small parameters
// (DEBOUNCE=4, LONG=100, PULSE=8, ACK_TIMEOUT=50, HOLDOFF=20).
// Expected latencies (hand-derived):
//   press drive -> debounced press : 6 cycles (2 sync + 4 debounce)
//   press drive -> cold pulse start: 6 + 100 = 106 cycles
//   h2f rise    -> busy low         : 2 sync + 1 transition + 20 holdoff = 23
//   debug start -> busy low         : 8 pulse + 20 holdoff = 28
//   warm start  -> ack_timeout set  : 8 pulse + 50 wait = 58, busy low at 78
// ---------------------------------------------------------------------------
module tb_hps_reset_req_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] button_n;
    logic       h2f_n;
    logic       cold_n;
    logic       warm_n;
    logic       debug_n;
    logic       busy;
    logic [1:0] last_req;
    logic       ack_to;

    always #5 clk = ~clk;

    hps_reset_req_gen #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (100),
        .PULSE_CYCLES    (8),
        .ACK_TIMEOUT     (50),
        .HOLDOFF_CYCLES  (20),
        .CNT_W           (32)
    ) dut (
        .clk_clk               (clk),
        .reset_reset_n         (rst_n),
        .button_n              (button_n),
        .h2f_reset_n           (h2f_n),
        .f2h_cold_reset_req_n  (cold_n),
        .f2h_warm_reset_req_n  (warm_n),
        .f2h_debug_reset_req_n (debug_n),
        .busy                  (busy),
        .last_req              (last_req),
        .ack_timeout           (ack_to)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Output monitor: pulse counts, widths, start cycles per request line
    // index 0 = warm, 1 = cold, 2 = debug
    // ------------------------------------------------------------------
    wire [2:0] req_now = {debug_n, cold_n, warm_n};
    logic [2:0] req_prev = 3'b111;
    int pcnt[3]   = '{0, 0, 0};
    int pw[3]     = '{0, 0, 0};
    int pstart[3] = '{0, 0, 0};
    int prun[3]   = '{0, 0, 0};
    logic busy_prev = 1'b0;
    logic ack_prev  = 1'b0;
    int busy_fall_cyc = 0;
    int busy_rises    = 0;
    int ack_rise_cyc  = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (req_prev[i] === 1'b1 && req_now[i] === 1'b0) begin
                pcnt[i]   <= pcnt[i] + 1;
                pstart[i] <= cyc;
                prun[i]   <= 1;
            end else if (req_now[i] === 1'b0) begin
                prun[i] <= prun[i] + 1;
            end else if (req_prev[i] === 1'b0) begin
                pw[i] <= prun[i];
            end
        end
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc <= cyc;
        if (busy_prev === 1'b0 && busy === 1'b1) busy_rises <= busy_rises + 1;
        if (ack_prev === 1'b0 && ack_to === 1'b1) ack_rise_cyc <= cyc;
        req_prev  <= req_now;
        busy_prev <= busy;
        ack_prev  <= ack_to;
    end

    // ------------------------------------------------------------------
    // HPS model: pulls h2f_reset_n low 5 cycles after a warm/cold request
    // starts, for 10 cycles.
    // ------------------------------------------------------------------
    logic hps_en = 1'b1;
    int   h2f_rise_cyc = 0;

    always begin
        @(negedge warm_n or negedge cold_n);
        if (hps_en) begin
            repeat (5) @(posedge clk);
            #1 h2f_n = 1'b0;
            repeat (10) @(posedge clk);
            #1 h2f_n = 1'b1;
            h2f_rise_cyc = cyc;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return warm_n;
            1:       return cold_n;
            2:       return debug_n;
            3:       return busy;
            default: return ack_to;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic val, input int bound);
        int n = 0;
        while (sig(sel) !== val && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) !== val) begin
            tests++;
            fails++;
            $error("FAIL %s: timed out after %0d cycles, observed %b expected %b",
                   tag, bound, sig(sel), val);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int press_cyc;
    int rises0;

    initial begin
        rst_n    = 1'b0;
        button_n = 2'b11;
        h2f_n    = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        check("rst_cold_n",  32'(cold_n),   32'd1);
        check("rst_warm_n",  32'(warm_n),   32'd1);
        check("rst_debug_n", 32'(debug_n),  32'd1);
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_last",    32'(last_req), 32'd0);
        check("rst_ack_to",  32'(ack_to),   32'd0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // ---------------- warm ----------------
        $display("[TB] warm request: 30-cycle press, HPS acknowledges");
        button_n[0] = 1'b0;
        repeat (30) @(negedge clk);
        button_n[0] = 1'b1;
        wait_for("warm_start", 0, 1'b0, 40);
        wait_for("warm_idle", 3, 1'b0, 100);
        repeat (2) @(negedge clk);
        check("warm_count",    32'(pcnt[0]), 32'd1);
        check("warm_width",    32'(pw[0]), 32'd8);
        check("warm_last",     32'(last_req), 32'd1);
        check("warm_busy_lat", 32'(busy_fall_cyc - h2f_rise_cyc), 32'd23);
        check("warm_no_cold",  32'(pcnt[1]), 32'd0);
        check("warm_ack_to",   32'(ack_to), 32'd0);

        // ---------------- cold ----------------
        $display("[TB] cold request: 200-cycle hold");
        press_cyc   = cyc;
        button_n[0] = 1'b0;
        repeat (200) @(negedge clk);
        button_n[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("cold_count",   32'(pcnt[1]), 32'd1);
        check("cold_width",   32'(pw[1]), 32'd8);
        check("cold_latency", 32'(pstart[1] - press_cyc), 32'd106);
        check("cold_no_warm", 32'(pcnt[0]), 32'd1);
        check("cold_last",    32'(last_req), 32'd2);
        check("cold_idle",    32'(busy), 32'd0);

        // ---------------- debug + dropped warm ----------------
        $display("[TB] debug request, button0 press during HOLDOFF");
        button_n[1] = 1'b0;
        wait_for("debug_start", 2, 1'b0, 30);
        button_n[1] = 1'b1;
        wait_for("debug_end", 2, 1'b1, 20);
        repeat (4) @(negedge clk);
        button_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        button_n[0] = 1'b1;
        wait_for("debug_idle", 3, 1'b0, 60);
        repeat (30) @(negedge clk);
        check("debug_count",    32'(pcnt[2]), 32'd1);
        check("debug_width",    32'(pw[2]), 32'd8);
        check("debug_busy_lat", 32'(busy_fall_cyc - pstart[2]), 32'd28);
        check("debug_dropped",  32'(pcnt[0]), 32'd1);
        check("debug_last",     32'(last_req), 32'd3);
        check("debug_idle_end", 32'(busy), 32'd0);

        // ---------------- ack timeout ----------------
        $display("[TB] warm request with no HPS acknowledge");
        hps_en      = 1'b0;
        button_n[0] = 1'b0;
        repeat (10) @(negedge clk);
        button_n[0] = 1'b1;
        wait_for("to_start", 0, 1'b0, 30);
        wait_for("to_flag", 4, 1'b1, 80);
        wait_for("to_idle", 3, 1'b0, 40);
        repeat (2) @(negedge clk);
        check("to_flag_lat", 32'(ack_rise_cyc - pstart[0]), 32'd58);
        check("to_idle_lat", 32'(busy_fall_cyc - pstart[0]), 32'd78);
        check("to_sticky",   32'(ack_to), 32'd1);
        check("to_last",     32'(last_req), 32'd1);
        check("to_width",    32'(pw[0]), 32'd8);
        button_n[1] = 1'b0;
        wait_for("to_next_start", 2, 1'b0, 30);
        check("to_cleared",  32'(ack_to), 32'd0);
        button_n[1] = 1'b1;
        wait_for("to_next_idle", 3, 1'b0, 60);
        repeat (10) @(negedge clk);

        // ---------------- glitches ----------------
        $display("[TB] glitch: ten 3-cycle pulses on button0");
        rises0 = busy_rises;
        for (int k = 0; k < 10; k++) begin
            button_n[0] = 1'b0;
            repeat (3) @(negedge clk);
            button_n[0] = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("glitch_no_busy", 32'(busy_rises - rises0), 32'd0);
        check("glitch_no_warm", 32'(pcnt[0]), 32'd2);
        check("glitch_busy",    32'(busy), 32'd0);

        // ---------------- async reset mid-ASSERT ----------------
        $display("[TB] asynchronous reset during ASSERT");
        button_n[0] = 1'b0;
        repeat (10) @(negedge clk);
        button_n[0] = 1'b1;
        wait_for("ar_start", 0, 1'b0, 30);
        repeat (2) @(negedge clk);
        check("ar_pre_low", 32'(warm_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_warm_n", 32'(warm_n),   32'd1);
        check("ar_busy",   32'(busy),     32'd0);
        check("ar_last",   32'(last_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("ar_after_busy", 32'(busy),   32'd0);
        check("ar_after_warm", 32'(warm_n), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
